// File: rtl/mips_register_file_if.sv
// Operand-fetch and write-back bus between the datapath and the MIPS register file.
// The master drives indices and write-back; the slave (register file) returns operands.
interface mips_register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] read_reg1;
  logic [ADDR_WIDTH-1:0] read_reg2;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  reg_write;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;

  modport master (
    output read_reg1, read_reg2, write_reg, write_data, reg_write,
    input  read_data1, read_data2
  );

  modport slave (
    input  read_reg1, read_reg2, write_reg, write_data, reg_write,
    output read_data1, read_data2
  );
endinterface

// File: rtl/mips_register_file.sv
// 32-entry MIPS register file: two combinational read ports, one write port, $zero hardwired.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module mips_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic                clk,
  input logic                rst_n,
  mips_register_file_if.slave rf
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
  // Low until the first edge after reset release, so a write coincident with release is dropped.
  logic                  active_reg;
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] read_idx [2];
  logic [DATA_WIDTH-1:0] read_val [2];

  assign write_en = active_reg && rf.reg_write && (rf.write_reg != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_reg <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      active_reg <= 1'b1;
      if (write_en) begin
        regs_reg[rf.write_reg] <= rf.write_data;
      end
    end
  end

  assign read_idx[0] = rf.read_reg1;
  assign read_idx[1] = rf.read_reg2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
`ifdef REGFILE_BYPASS_EN
      logic bypass_hit;
      assign bypass_hit = rst_n && active_reg && rf.reg_write &&
                          (rf.write_reg != '0) && (rf.write_reg == read_idx[gi]);
      assign read_val[gi] = bypass_hit              ? rf.write_data :
                            (read_idx[gi] == '0)    ? '0            :
                                                      regs_reg[read_idx[gi]];
`else
      assign read_val[gi] = (read_idx[gi] == '0) ? '0 : regs_reg[read_idx[gi]];
`endif
    end
  endgenerate

  assign rf.read_data1 = read_val[0];
  assign rf.read_data2 = read_val[1];
endmodule

// File: tb/tb_mips_register_file.sv
// Directed test of mips_register_file: stimulus queues expected operands, a monitor compares.
module tb_mips_register_file;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct {
    string       name;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;

  mips_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf ();

  mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf.slave)
  );

  always #5 clk = ~clk;

  // Monitor: whenever the bench signals that operands are presented, pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (rf.read_data1 !== e.exp1 || rf.read_data2 !== e.exp2) begin
          miscompares++;
          $display("FAIL %s: read_data1=%h read_data2=%h, expected %h %h",
                   e.name, rf.read_data1, rf.read_data2, e.exp1, e.exp2);
        end else begin
          $display("ok   %s: read_data1=%h read_data2=%h", e.name, rf.read_data1, rf.read_data2);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_rd(input string name, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    rf.read_reg1 = r1;
    rf.read_reg2 = r2;
    #1;
    e.name = name;
    e.exp1 = e1;
    e.exp2 = e2;
    exp_q.push_back(e);
    ->sample_ev;
    #1;
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [31:0] data);
    rf.reg_write  = 1'b1;
    rf.write_reg  = idx;
    rf.write_data = data;
    tick();
    rf.reg_write  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hazard_exp;
    rf.read_reg1  = 5'd5;
    rf.read_reg2  = 5'd6;
    rf.write_reg  = 5'd0;
    rf.write_data = 32'h0;
    rf.reg_write  = 1'b0;
    @(negedge clk);
    expect_rd("reset_state", 5'd5, 5'd6, 32'h0, 32'h0);

    // Release reset; first edge only arms the write port.
    rst_n = 1'b1;
    tick();
    write_reg(5'd5, 32'h1234_5678);
    expect_rd("preload_reg5", 5'd5, 5'd0, 32'h1234_5678, 32'h0);

    // Asynchronous reset between edges, with a write pending that must be lost.
    rf.reg_write  = 1'b1;
    rf.write_reg  = 5'd6;
    rf.write_data = 32'hCAFE_F00D;
    #2;
    rst_n = 1'b0;
    expect_rd("async_reset_reg5", 5'd5, 5'd6, 32'h0, 32'h0);
    tick();
    expect_rd("reset_hold_writes_blocked", 5'd6, 5'd5, 32'h0, 32'h0);

    // Release coincident with a write to reg7: the write must be ignored.
    rf.write_reg  = 5'd7;
    rf.write_data = 32'h0000_0055;
    rst_n = 1'b1;
    tick();
    rf.reg_write = 1'b0;
    expect_rd("release_race_reg7", 5'd7, 5'd6, 32'h0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      expect_rd($sformatf("post_reset_idx%0d", i), 5'(i), 5'(31 - i), 32'h0, 32'h0);
    end

    write_reg(5'd8, 32'hDEAD_BEEF);
    write_reg(5'd9, 32'h0000_00FF);
    expect_rd("read_r8_r9", 5'd8, 5'd9, 32'hDEAD_BEEF, 32'h0000_00FF);
    expect_rd("both_ports_r8", 5'd8, 5'd8, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    expect_rd("swap_r9_r8", 5'd9, 5'd8, 32'h0000_00FF, 32'hDEAD_BEEF);

    // $zero: writes discarded, never forwarded.
    rf.reg_write  = 1'b1;
    rf.write_reg  = 5'd0;
    rf.write_data = 32'hFFFF_FFFF;
    expect_rd("zero_before_edge", 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    rf.reg_write = 1'b0;
    expect_rd("zero_after_edge", 5'd0, 5'd8, 32'h0, 32'hDEAD_BEEF);
    tick();
    tick();
    expect_rd("zero_later", 5'd0, 5'd0, 32'h0, 32'h0);

    // Write disable.
    write_reg(5'd3, 32'h0000_0011);
    rf.reg_write  = 1'b0;
    rf.write_reg  = 5'd3;
    rf.write_data = 32'hAAAA_AAAA;
    tick();
    expect_rd("write_disabled_r3", 5'd3, 5'd9, 32'h0000_0011, 32'h0000_00FF);

    // Same-cycle read/write hazard on reg4.
    write_reg(5'd4, 32'h0000_0001);
    rf.reg_write  = 1'b1;
    rf.write_reg  = 5'd4;
    rf.write_data = 32'h0000_0002;
`ifdef REGFILE_BYPASS_EN
    hazard_exp = 32'h0000_0002;
`else
    hazard_exp = 32'h0000_0001;
`endif
    expect_rd("hazard_before_edge", 5'd4, 5'd3, hazard_exp, 32'h0000_0011);
    expect_rd("hazard_both_ports", 5'd4, 5'd4, hazard_exp, hazard_exp);
    tick();
    rf.reg_write = 1'b0;
    expect_rd("hazard_after_edge", 5'd4, 5'd4, 32'h0000_0002, 32'h0000_0002);
    expect_rd("regs_retained", 5'd8, 5'd5, 32'hDEAD_BEEF, 32'h0);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) begin
      ->sample_ev;
      #1;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left in queue, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
